// File: rtl/stopwatch_display_mux.sv
// stopwatch_display_mux
// Drives a 4-digit common-anode 7-segment display (MM.SS) from the stopwatch
// core. Once per scan frame the inputs are captured and converted to BCD by
// a sequential shift-add-3 engine, so a single frame never mixes two counts.
// Optional feature macro: BLINK_ON_PAUSE_EN (blank the display in a blink
// pattern while the stopwatch is paused). Without it, status is ignored.

module stopwatch_display_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       ovf
);

    localparam int               DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       CONV_LAST = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_LOAD
    } state_t;

    // Scan timing
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             tick;
    logic             frame_wrap;
    logic             snapshot;

    // Conversion FSM
    state_t           state_q, state_d;
    logic [2:0]       iter_q, iter_d;
    logic             start_conv;
    logic             conv_en;
    logic             load_en;

    // Datapath: {tens, units, binary} shift registers and displayed BCD
    logic [14:0]      min_sh_q, min_sh_d;
    logic [14:0]      sec_sh_q, sec_sh_d;
    logic [15:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [6:0]       min_clip;

    // Registered display outputs
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;
    logic [3:0]       an_n_q, an_n_d;
    logic [3:0]       digit;
    logic             lit;

    // One shift-add-3 step: correct any BCD nibble >= 5, then shift left.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [14:0] a;
        a = v;
        if (a[10:7] >= 4'd5) begin
            a[10:7] = a[10:7] + 4'd3;
        end
        if (a[14:11] >= 4'd5) begin
            a[14:11] = a[14:11] + 4'd3;
        end
        return {a[13:0], 1'b0};
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Refresh divider, digit index and snapshot request generation.
    always_comb begin
        tick       = (div_q == DIV_LAST);
        frame_wrap = tick && (idx_q == 2'd3);
        snapshot   = frame_wrap || pending_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        pending_d  = 1'b0;
    end

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion FSM next state: capture, seven iterations, one load cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (snapshot) state_d = S_CONV;
            S_CONV:  if (iter_q == CONV_LAST) state_d = S_LOAD;
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion FSM outputs.
    always_comb begin
        start_conv = 1'b0;
        conv_en    = 1'b0;
        load_en    = 1'b0;
        case (state_q)
            S_IDLE:  start_conv = snapshot;
            S_CONV:  conv_en    = 1'b1;
            S_LOAD:  load_en    = 1'b1;
            default: ;
        endcase
    end

    // Snapshot capture, shift-add-3 iterations and display register load.
    always_comb begin
        min_clip = (minutes > 8'd99) ? 7'd99 : minutes[6:0];
        min_sh_d = min_sh_q;
        sec_sh_d = sec_sh_q;
        iter_d   = iter_q;
        ovf_d    = ovf_q;
        disp_d   = disp_q;
        if (start_conv) begin
            min_sh_d = {8'd0, min_clip};
            sec_sh_d = {8'd0, 1'b0, seconds};
            ovf_d    = (minutes > 8'd99);
            iter_d   = 3'd0;
        end else if (conv_en) begin
            min_sh_d = dd_step(min_sh_q);
            sec_sh_d = dd_step(sec_sh_q);
            iter_d   = iter_q + 3'd1;
        end else if (load_en) begin
            disp_d = {min_sh_q[14:7], sec_sh_q[14:7]};
        end
    end

`ifdef BLINK_ON_PAUSE_EN
    localparam int                 FRAME_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_vis_q, blink_vis_d;

    // Blink phase: toggles every BLINK_FRAMES frames while paused, lit otherwise.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_vis_d = blink_vis_q;
        if (status != 2'b10) begin
            frame_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end

    // The next-state value is used so leaving PAUSED relights on the next edge.
    assign lit = blink_vis_d;
`else
    logic unused_cfg;
    assign unused_cfg = (^status) ^ (BLINK_FRAMES == 0);
    assign lit        = 1'b1;
`endif

    // Digit select and segment/anode/decimal-point encoding for the next edge.
    always_comb begin
        case (idx_q)
            2'd0:    digit = disp_q[3:0];
            2'd1:    digit = disp_q[7:4];
            2'd2:    digit = disp_q[11:8];
            default: digit = disp_q[15:12];
        endcase
        an_n_d  = ~(4'b0001 << idx_q);
        seg_n_d = seg_decode(digit);
        dp_n_d  = (idx_q != 2'd2);
        if (!lit) begin
            an_n_d  = 4'hF;
            seg_n_d = 7'h7F;
            dp_n_d  = 1'b1;
        end
    end

    // All scan, datapath and output registers; reset leaves a snapshot pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= 2'd0;
            pending_q <= 1'b1;
            iter_q    <= 3'd0;
            min_sh_q  <= '0;
            sec_sh_q  <= '0;
            disp_q    <= '0;
            ovf_q     <= 1'b0;
            seg_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
            an_n_q    <= 4'hF;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            iter_q    <= iter_d;
            min_sh_q  <= min_sh_d;
            sec_sh_q  <= sec_sh_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
            an_n_q    <= an_n_d;
        end
    end

    assign seg_n = seg_n_q;
    assign dp_n  = dp_n_q;
    assign an_n  = an_n_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// tb_stopwatch_display_mux
// Scan-frame scoreboard bench for stopwatch_display_mux (REFRESH_DIV=16,
// BLINK_FRAMES=2). One vector is shown per 64-cycle frame; every digit slot
// of that frame is sampled mid-slot and compared against queued expectations.
`timescale 1ns/1ps

module tb_stopwatch_display_mux;

    localparam int REFRESH_DIV  = 16;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = 4 * REFRESH_DIV;
    localparam int NVEC         = 6;
`ifdef BLINK_ON_PAUSE_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       ovf;

    // digits packed as {min tens, min units, sec tens, sec units}
    typedef struct {
        logic [7:0]  minutes;
        logic [5:0]  seconds;
        logic [15:0] digits;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ovf;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   cyc;
    int   checks;
    int   errors;

    stopwatch_display_mux #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .minutes(minutes),
        .seconds(seconds),
        .status (status),
        .seg_n  (seg_n),
        .dp_n   (dp_n),
        .an_n   (an_n),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Advance to the negedge that follows posedge number t after reset release.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t       e;
        logic [3:0] one;
        minutes = v.minutes;
        seconds = v.seconds;
        for (int d = 0; d < 4; d++) begin
            one   = 4'b0001 << d;
            e.an  = ~one;
            e.seg = exp_seg(v.digits[4*d +: 4]);
            e.dp  = (d != 2);
            e.ovf = v.ovf;
            sb_q.push_back(e);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got an_n=%0h seg_n=%0h", tag, an_n, seg_n);
        end else begin
            e = sb_q.pop_front();
            compare({tag, " an_n"}, {4'd0, an_n}, {4'd0, e.an});
            compare({tag, " seg_n"}, {1'b0, seg_n}, {1'b0, e.seg});
            compare({tag, " dp_n"}, {7'd0, dp_n}, {7'd0, e.dp});
            compare({tag, " ovf"}, {7'd0, ovf}, {7'd0, e.ovf});
        end
    endtask

    task automatic checkReset(input string tag);
        compare({tag, " seg_n"}, {1'b0, seg_n}, 8'h7F);
        compare({tag, " an_n"}, {4'd0, an_n}, 8'h0F);
        compare({tag, " dp_n"}, {7'd0, dp_n}, 8'h01);
        compare({tag, " ovf"}, {7'd0, ovf}, 8'h00);
    endtask

    // Slot idx1 of the last table vector (100:60 -> sec tens 6) or blank.
    task automatic checkVisible(input string tag, input bit vis);
        compare({tag, " an_n"}, {4'd0, an_n}, vis ? 8'h0D : 8'h0F);
        compare({tag, " seg_n"}, {1'b0, seg_n}, vis ? {1'b0, exp_seg(4'd6)} : 8'h7F);
        compare({tag, " dp_n"}, {7'd0, dp_n}, 8'h01);
    endtask

    task automatic checkFrameSlots(input int base, input int f);
        for (int d = 0; d < 4; d++) begin
            goto(base + 12 + REFRESH_DIV * d);
            checkOutput($sformatf("frame%0d slot%0d", f, d));
        end
    endtask

    initial begin
        int   base;
        vec_t v;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        vecs[0] = '{8'd12,  6'd34, 16'h1234, 1'b0};
        vecs[1] = '{8'd12,  6'd35, 16'h1235, 1'b0};
        vecs[2] = '{8'd150, 6'd0,  16'h9900, 1'b1};
        vecs[3] = '{8'd5,   6'd0,  16'h0500, 1'b0};
        vecs[4] = '{8'd99,  6'd63, 16'h9963, 1'b0};
        vecs[5] = '{8'd100, 6'd60, 16'h9960, 1'b1};

        rst_n   = 1'b0;
        status  = 2'b01;
        minutes = 8'd0;
        seconds = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("reset");

        $display("[TB] table: one vector per frame, next vector driven while idx==1");
        applyStimulus(vecs[0]);
        rst_n = 1'b1;
        cyc   = 0;
        for (int f = 0; f < NVEC; f++) begin
            base = f * FRAME_CYC;
            goto(base + 12);
            checkOutput($sformatf("frame%0d slot0", f));
            goto(base + 20);
            if (f + 1 < NVEC) applyStimulus(vecs[f + 1]);
            else status = 2'b10;
            for (int d = 1; d < 4; d++) begin
                goto(base + 12 + REFRESH_DIV * d);
                checkOutput($sformatf("frame%0d slot%0d", f, d));
            end
        end

        $display("[TB] pause blink sequence");
        base = NVEC * FRAME_CYC;
        goto(base + 28);
        checkVisible("blink f0", 1'b1);
        goto(base + FRAME_CYC + 28);
        checkVisible("blink f1", !BLINK_ON);
        goto(base + 2 * FRAME_CYC + 28);
        checkVisible("blink f2", !BLINK_ON);
        goto(base + 3 * FRAME_CYC + 28);
        checkVisible("blink f3", 1'b1);
        goto(base + 5 * FRAME_CYC + 30);
        checkVisible("blink f5", !BLINK_ON);
        status = 2'b01;
        goto(base + 5 * FRAME_CYC + 31);
        checkVisible("unpause", 1'b1);

        $display("[TB] reset during conversion");
        base = (NVEC + 6) * FRAME_CYC;
        goto(base + 2);
        rst_n = 1'b0;
        goto(base + 3);
        checkReset("midconv reset");
        v = '{8'd42, 6'd17, 16'h4217, 1'b0};
        applyStimulus(v);
        goto(base + 4);
        rst_n = 1'b1;
        cyc   = 0;
        checkFrameSlots(0, 99);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
